// File: rtl/multichan_delay_aligned.sv
// N-channel programmable sample delay on one packed AXI-stream. All channels share
// one handshake, one write pointer and one fill count, so framing stays aligned.
module multichan_delay_aligned #(
  parameter int NUM_CH         = 2,
  parameter int WIDTH          = 16,
  parameter int MAX_DELAY_LOG2 = 10,
  parameter int SR_DELAY_BASE  = 128,
  parameter int SR_FLUSH       = 128 + NUM_CH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             set_stb,
  input  logic [7:0]                       set_addr,
  input  logic [31:0]                      set_data,
  input  logic [NUM_CH*WIDTH-1:0]          i_tdata,
  input  logic                             i_tlast,
  input  logic                             i_tvalid,
  output logic                             i_tready,
  output logic [NUM_CH*WIDTH-1:0]          o_tdata,
  output logic                             o_tlast,
  output logic                             o_tvalid,
  input  logic                             o_tready,
  output logic [NUM_CH*MAX_DELAY_LOG2-1:0] delay_rb
);

  localparam int DW    = MAX_DELAY_LOG2;
  localparam int DEPTH = 1 << DW;
  localparam logic [DW-1:0] MAX_DELAY = '1;

  logic [1:0]              rst_sync;
  logic                    rst_n;
  logic                    en;
  logic                    accept;
  logic                    flush_hit;
  logic [DW-1:0]           set_delay;
  logic [DW-1:0]           wr_ptr;
  logic [DW-1:0]           fill;
  logic [NUM_CH*DW-1:0]    delay_q;
  logic                    s1_valid;
  logic                    s1_last;
  logic [NUM_CH*WIDTH-1:0] s1_data;
  logic [NUM_CH-1:0]       s1_zero;
  logic [NUM_CH-1:0]       s1_bypass;
  logic [NUM_CH*WIDTH-1:0] mux_data;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign en        = ~o_tvalid | o_tready;
  assign i_tready  = ~s1_valid | en;
  assign accept    = i_tvalid & i_tready;
  assign flush_hit = set_stb && (set_addr == 8'(SR_FLUSH));
  assign set_delay = (|set_data[31:DW]) ? MAX_DELAY : set_data[DW-1:0];
  assign delay_rb  = delay_q;

  // Per-channel history RAMs; the read is only advanced on accept so a stalled
  // stage 1 keeps its RAM word.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [DW-1:0]    rd_addr;

    assign rd_addr = wr_ptr - delay_q[c*DW +: DW];

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[wr_ptr] <= i_tdata[c*WIDTH +: WIDTH];
        ram_q       <= mem[rd_addr];
      end
    end

    assign mux_data[c*WIDTH +: WIDTH] = s1_bypass[c] ? s1_data[c*WIDTH +: WIDTH] :
                                        s1_zero[c]   ? '0 : ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q   <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      s1_zero   <= '0;
      s1_bypass <= '0;
      o_tvalid  <= 1'b0;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (set_stb && (set_addr == 8'(SR_DELAY_BASE + c))) delay_q[c*DW +: DW] <= set_delay;
      end

      // A zero flag marks reads that reach back before the last flush or reset.
      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        s1_data <= i_tdata;
        s1_last <= i_tlast;
        for (int c = 0; c < NUM_CH; c++) begin
          s1_zero[c]   <= delay_q[c*DW +: DW] > fill;
          s1_bypass[c] <= delay_q[c*DW +: DW] == '0;
        end
        if (fill != MAX_DELAY) fill <= fill + 1'b1;
      end
      if (flush_hit) fill <= '0;

      if (accept)  s1_valid <= 1'b1;
      else if (en) s1_valid <= 1'b0;

      if (en) begin
        o_tvalid <= s1_valid;
        if (s1_valid) begin
          o_tdata <= mux_data;
          o_tlast <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_multichan_delay_aligned.sv
// Scoreboard bench for multichan_delay_aligned: a history-array reference model
// predicts every output sample, and a separate monitor compares what the DUT presents.
module tb_multichan_delay_aligned;

  localparam int NUM_CH    = 2;
  localparam int WIDTH     = 16;
  localparam int DW        = 10;
  localparam int DMAX      = (1 << DW) - 1;
  localparam int SR_BASE   = 128;
  localparam int SR_FLUSH  = 128 + NUM_CH;
  localparam int DATA_W    = NUM_CH * WIDTH;

  logic                   clk;
  logic                   reset_n;
  logic                   set_stb;
  logic [7:0]             set_addr;
  logic [31:0]            set_data;
  logic [DATA_W-1:0]      i_tdata;
  logic                   i_tlast;
  logic                   i_tvalid;
  logic                   i_tready;
  logic [DATA_W-1:0]      o_tdata;
  logic                   o_tlast;
  logic                   o_tvalid;
  logic                   o_tready;
  logic [NUM_CH*DW-1:0]   delay_rb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int first_acc = -1;
  int first_valid = -1;
  int in_cnt = 0;
  int out_cnt = 0;
  bit stress_done = 0;

  logic [DATA_W-1:0] hist [$];
  logic [DATA_W:0]   exp_q [$];
  int                mdelay [NUM_CH];
  int                flush_start = 0;
  logic [DATA_W-1:0] m_exp;
  int                m_n;
  int                m_d;

  multichan_delay_aligned #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_DELAY_LOG2(DW),
    .SR_DELAY_BASE(SR_BASE), .SR_FLUSH(SR_FLUSH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .delay_rb(delay_rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-ready pattern: always ready, random, or stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_tready = 1'b1;
      1:       o_tready = 1'($urandom_range(0, 1));
      default: o_tready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_delay(input logic [31:0] v);
    return (v > 32'(DMAX)) ? DMAX : int'(v);
  endfunction

  // Reference model: output n, channel c is input n-delay, or 0 when that index
  // falls before the most recent flush or reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      hist.delete();
      exp_q.delete();
      flush_start = 0;
      for (int c = 0; c < NUM_CH; c++) mdelay[c] = 0;
    end else begin
      if (i_tvalid && i_tready) begin
        m_n = hist.size();
        for (int c = 0; c < NUM_CH; c++) begin
          m_d = mdelay[c];
          if (m_d == 0)                    m_exp[c*WIDTH +: WIDTH] = i_tdata[c*WIDTH +: WIDTH];
          else if (m_n - m_d < flush_start) m_exp[c*WIDTH +: WIDTH] = '0;
          else                              m_exp[c*WIDTH +: WIDTH] = hist[m_n - m_d][c*WIDTH +: WIDTH];
        end
        exp_q.push_back({i_tlast, m_exp});
        hist.push_back(i_tdata);
        in_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (set_stb) begin
        for (int c = 0; c < NUM_CH; c++)
          if (set_addr == 8'(SR_BASE + c)) mdelay[c] = sat_delay(set_data);
        if (set_addr == 8'(SR_FLUSH)) flush_start = hist.size();
      end
    end
  end

  // Monitor: whatever is presented must match the queue head, stalled or not.
  always @(negedge clk) begin
    if (reset_n && o_tvalid) begin
      if (first_valid < 0) first_valid = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(o_tvalid), 64'd0);
      end else begin
        check("o_tdata", 64'(o_tdata), 64'(exp_q[0][DATA_W-1:0]));
        check("o_tlast", 64'(o_tlast), 64'(exp_q[0][DATA_W]));
        if (o_tready) void'(exp_q.pop_front());
      end
      if (o_tready) out_cnt++;
    end
  end

  task automatic write_setting(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic send_samples(input int count, input bit rnd, input bit rand_valid);
    int sent = 0;
    int guard = 0;
    bit acc;
    bit fresh = 1'b1;
    while (sent < count) begin
      if (fresh) begin
        if (rnd) i_tdata = DATA_W'({$urandom, $urandom});
        else     i_tdata = {16'(sent + 101), 16'(sent + 1)};
        i_tlast = (sent == count - 1) || (rand_valid && $urandom_range(0, 7) == 0);
        fresh = 1'b0;
      end
      i_tvalid = !(rand_valid && $urandom_range(0, 1) == 0);
      @(negedge clk);
      acc = i_tvalid && i_tready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        fresh = 1'b1;
      end
      guard++;
      if (guard > 20 * count + 200) begin
        check("stream_timeout", 64'(sent), 64'(count));
        break;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk); #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    check("reset_o_tvalid", 64'(o_tvalid), 64'd0);
    check("reset_o_tdata", 64'(o_tdata), 64'd0);
    check("reset_o_tlast", 64'(o_tlast), 64'd0);
    check("reset_delay_rb", 64'(delay_rb), 64'd0);
    check("reset_i_tready", 64'(i_tready), 64'd1);

    $display("[TB] zero delay ramp");
    first_acc = -1;
    first_valid = -1;
    send_samples(8, 1'b0, 1'b0);
    wait_drain();
    check("latency", 64'(first_valid - first_acc), 64'd2);

    $display("[TB] delays {3,0} ramp");
    write_setting(8'(SR_BASE), 32'd3);
    write_setting(8'(SR_BASE + 1), 32'd0);
    check("delay_rb_3_0", 64'(delay_rb), 64'({10'd0, 10'd3}));
    send_samples(8, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] saturating delay 5000");
    write_setting(8'(SR_BASE), 32'd5000);
    check("delay_rb_sat", 64'(delay_rb[DW-1:0]), 64'd1023);
    send_samples(1100, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] flush with delay 4");
    write_setting(8'(SR_BASE), 32'd4);
    write_setting(8'(SR_BASE + 1), 32'd4);
    send_samples(20, 1'b0, 1'b0);
    write_setting(8'(SR_FLUSH), 32'd0);
    send_samples(20, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] random handshakes, delays {7,2}");
    write_setting(8'(SR_BASE), 32'd7);
    write_setting(8'(SR_BASE + 1), 32'd2);
    ready_mode = 1;
    in_cnt = 0;
    out_cnt = 0;
    send_samples(10000, 1'b1, 1'b1);
    wait_drain();
    check("count_in_eq_out", 64'(out_cnt), 64'(in_cnt));

    $display("[TB] random settings traffic");
    stress_done = 1'b0;
    fork
      begin
        send_samples(2000, 1'b1, 1'b1);
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          int r;
          r = $urandom_range(0, 29);
          set_stb = (r < 5);
          case (r)
            0:       begin set_addr = 8'(SR_BASE);     set_data = $urandom_range(0, 20); end
            1:       begin set_addr = 8'(SR_BASE + 1); set_data = $urandom_range(0, 20); end
            2:       begin set_addr = 8'(SR_FLUSH);    set_data = '0; end
            3:       begin set_addr = 8'(SR_FLUSH + 1); set_data = $urandom_range(0, 20); end
            4:       begin set_addr = 8'(SR_BASE);     set_data = 32'hFFFF_0000; end
            default: begin set_addr = '0;              set_data = '0; end
          endcase
          @(posedge clk); #1;
        end
        set_stb = 1'b0;
      end
    join
    wait_drain();
    check("count_in_eq_out_stress", 64'(out_cnt), 64'(in_cnt));

    $display("[TB] reset mid-stream");
    write_setting(8'(SR_BASE), 32'd3);
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      i_tvalid = 1'b1;
      i_tdata  = {16'(k + 500), 16'(k + 50)};
      i_tlast  = (k == 2);
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_o_tvalid", 64'(o_tvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_o_tvalid", 64'(o_tvalid), 64'd0);
    check("async_reset_o_tdata", 64'(o_tdata), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_delay_rb", 64'(delay_rb), 64'd0);
    send_samples(8, 1'b0, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
